// File: rtl/burst_sram_ctrl.sv
// Burst initiator for a single-port synchronous SRAM: one beat per cycle,
// host write stream under valid/ready, read stream returned valid-only.
module burst_sram_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // state   | meaning
  // S_IDLE  | waiting for a burst request
  // S_WRITE | taking host write beats, one SRAM write per handshake
  // S_READ  | issuing SRAM reads on consecutive cycles
  // S_DRAIN | last read issued, waiting for its data to return
  // S_DONE  | done pulse cycle, back to idle next
  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);

  state_t              state, state_d;
  logic [LEN_W-1:0]    cnt, cnt_d, len, len_d, len_clamp;
  logic [ADDR_W-1:0]   base, base_d, beat_addr;
  logic                mem_cs_d, mem_we_d, done_d, rd_pend;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_d;

  assign req_ready = (state == S_IDLE);
  assign wr_ready  = (state == S_WRITE);
  assign len_clamp = (req_len > MAX_LEN) ? MAX_LEN : req_len;
  // Truncating the beat count gives the modulo-depth wrap for free.
  assign beat_addr = base + cnt[ADDR_W-1:0];

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    len_d       = len;
    base_d      = base;
    mem_cs_d    = 1'b0;
    mem_we_d    = 1'b0;
    done_d      = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          base_d = req_addr;
          len_d  = len_clamp;
          cnt_d  = '0;
          if (len_clamp == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (req_we) begin
            state_d = S_WRITE;
          end else begin
            // First read issues straight from the request fields.
            state_d    = S_READ;
            mem_cs_d   = 1'b1;
            mem_addr_d = req_addr;
            cnt_d      = LEN_W'(1);
          end
        end
      end
      S_WRITE: begin
        if (wr_valid) begin
          mem_cs_d    = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = beat_addr;
          mem_wdata_d = wr_data;
          cnt_d       = cnt + 1'b1;
          if (cnt_d == len) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_READ: begin
        if (cnt == len) begin
          state_d = S_DRAIN;
        end else begin
          mem_cs_d   = 1'b1;
          mem_addr_d = beat_addr;
          cnt_d      = cnt + 1'b1;
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      len       <= '0;
      base      <= '0;
      mem_cs    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      rd_pend   <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      len       <= len_d;
      base      <= base_d;
      mem_cs    <= mem_cs_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      done      <= done_d;
      // SRAM data is valid the cycle after issue; register it once more.
      rd_pend   <= mem_cs && !mem_we;
      rd_valid  <= rd_pend;
      if (rd_pend) rd_data <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_burst_sram_ctrl.sv
// Directed bench for burst_sram_ctrl with a behavioural 16x8 SRAM and an
// event monitor; expected traffic is computed from the request fields.
module tb_burst_sram_ctrl;
  localparam int AW = 4, DW = 8, LW = 5;

  logic          clk = 1'b0;
  logic          rst_n, req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr, mem_addr;
  logic [LW-1:0] req_len;
  logic [DW-1:0] wr_data, rd_data, mem_wdata, mem_rdata;
  logic          wr_valid, wr_ready, rd_valid, done, mem_cs, mem_we;

  always #5 clk = ~clk;

  burst_sram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_len(req_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  // SRAM model, preloaded with 0x50+i on the first reset edge
  logic [7:0] sram [16];
  bit loaded = 1'b0;
  always @(posedge clk) begin
    if (!rst_n && !loaded) begin
      for (int i = 0; i < 16; i++) sram[i] <= 8'h50 + 8'(i);
      loaded <= 1'b1;
    end else begin
      if (mem_cs && !mem_we) mem_rdata <= sram[mem_addr];
      if (mem_cs && mem_we) sram[mem_addr] <= mem_wdata;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int c; logic we; logic [3:0] a; logic [7:0] d;} mev_t;
  typedef struct {int c; logic [7:0] d;} rev_t;
  mev_t mq[$];
  rev_t rq[$];
  int   dq[$];
  int   rdy_cyc = -1, watch_from = 0, we_bad = 0;

  always begin
    mev_t m;
    rev_t r;
    @(posedge clk);
    #2;
    if (mem_cs === 1'b1) begin
      m.c = cyc; m.we = mem_we; m.a = mem_addr; m.d = mem_wdata;
      mq.push_back(m);
    end
    if (rd_valid === 1'b1) begin
      r.c = cyc; r.d = rd_data;
      rq.push_back(r);
    end
    if (done === 1'b1) dq.push_back(cyc);
    if (req_ready === 1'b1 && rdy_cyc < 0 && cyc > watch_from) rdy_cyc = cyc;
    if (mem_we === 1'b1 && mem_cs !== 1'b1) we_bad++;
  end

  int errors = 0, checks = 0;
  logic [7:0] exp_mem [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {logic we; logic [3:0] base; logic [4:0] len; int eff; int gap; logic [7:0] dbase;} vec_t;
  vec_t vecs[11];

  task automatic run_burst(input vec_t v);
    int acc, k, exp_done;
    int hs[$];
    bit gapped;
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_we = v.we; req_addr = v.base; req_len = v.len;
    acc = cyc; watch_from = cyc; rdy_cyc = -1;
    mq.delete(); rq.delete(); dq.delete();
    @(negedge clk);
    req_valid = 1'b0;
    if (v.we) begin
      k = 0; gapped = 1'b0;
      while (k < v.eff) begin
        chk("wr_ready_in_write", wr_ready, 1);
        if (k == v.gap && !gapped) begin
          wr_valid = 1'b0; gapped = 1'b1;
        end else begin
          wr_valid = 1'b1; wr_data = v.dbase + 8'(k);
          hs.push_back(cyc);
          exp_mem[(v.base + k) % 16] = v.dbase + 8'(k);
          k++;
        end
        @(negedge clk);
      end
      wr_valid = 1'b0;
      chk("wr_ready_after", wr_ready, 0);
    end
    repeat (v.eff + 6) @(negedge clk);

    chk("n_mem", mq.size(), v.eff);
    for (int i = 0; i < v.eff && i < mq.size(); i++) begin
      chk("mem_cyc", mq[i].c, v.we ? hs[i] + 1 : acc + 1 + i);
      chk("mem_addr", mq[i].a, (v.base + i) % 16);
      chk("mem_we", mq[i].we, v.we);
      if (v.we) chk("mem_wdata", mq[i].d, v.dbase + 8'(i));
    end
    chk("n_rd", rq.size(), v.we ? 0 : v.eff);
    if (!v.we)
      for (int i = 0; i < v.eff && i < rq.size(); i++) begin
        chk("rd_cyc", rq[i].c, acc + 3 + i);
        chk("rd_data", rq[i].d, exp_mem[(v.base + i) % 16]);
      end
    if (v.eff == 0) exp_done = acc + 1;
    else if (v.we)  exp_done = hs[hs.size() - 1] + 1;
    else            exp_done = acc + v.eff + 2;
    chk("n_done", dq.size(), 1);
    if (dq.size() > 0) chk("done_cyc", dq[0], exp_done);
    chk("req_ready_return", rdy_cyc, exp_done + 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc;
    vecs[0]  = '{1'b1, 4'd3,  5'd4,  4,  -1, 8'hA0};
    vecs[1]  = '{1'b1, 4'd9,  5'd4,  4,   2, 8'hB0};
    vecs[2]  = '{1'b0, 4'd14, 5'd4,  4,  -1, 8'h00};
    vecs[3]  = '{1'b0, 4'd3,  5'd4,  4,  -1, 8'h00};
    vecs[4]  = '{1'b1, 4'd7,  5'd0,  0,  -1, 8'h00};
    vecs[5]  = '{1'b0, 4'd2,  5'd0,  0,  -1, 8'h00};
    vecs[6]  = '{1'b0, 4'd0,  5'd20, 16, -1, 8'h00};
    vecs[7]  = '{1'b1, 4'd15, 5'd2,  2,  -1, 8'hC0};
    vecs[8]  = '{1'b0, 4'd15, 5'd1,  1,  -1, 8'h00};
    vecs[9]  = '{1'b1, 4'd5,  5'd31, 16,  5, 8'hD0};
    vecs[10] = '{1'b0, 4'd0,  5'd16, 16, -1, 8'h00};
    for (int i = 0; i < 16; i++) exp_mem[i] = 8'h50 + 8'(i);

    // reset held with a pending request
    rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd2; req_len = 5'd2;
    wr_valid = 1'b0; wr_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_mem_cs", mem_cs, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_accept_cs", mem_cs, 1);
    chk("post_rst_accept_addr", mem_addr, 2);
    chk("post_rst_req_ready", req_ready, 0);
    req_valid = 1'b0;
    repeat (8) @(negedge clk);

    foreach (vecs[i]) run_burst(vecs[i]);

    // reset during a read burst
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd0; req_len = 5'd8; acc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("midrst_beat_active", mem_cs, 1);
    chk("midrst_beat_addr", mem_addr, 1);
    rst_n = 1'b0;
    dq.delete();
    @(negedge clk);
    chk("midrst_mem_cs", mem_cs, 0);
    chk("midrst_rd_valid", rd_valid, 0);
    chk("midrst_req_ready", req_ready, 1);
    chk("midrst_done", done, 0);
    rst_n = 1'b1;
    mq.delete(); rq.delete();
    repeat (10) @(negedge clk);
    chk("midrst_no_done", dq.size(), 0);
    chk("midrst_no_mem", mq.size(), 0);
    chk("midrst_no_rd", rq.size(), 0);
    chk("midrst_cycle_ref", cyc - acc, 13);

    chk("we_without_cs", we_bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/burst_sram_ctrl.md
Name: burst_sram_ctrl

Overview:
Burst initiator that drives a single-port, 16x8 synchronous burst SRAM target one beat per cycle. It accepts a burst request (direction, base address, length) from a host. Writes pull data from a host stream under valid/ready. Reads push SRAM data back to the host as a valid-qualified stream. It sits between host logic and the SRAM and owns all address sequencing and wrap-around.

Parameters:
ADDR_W, 4, SRAM address width (depth 2^ADDR_W)
DATA_W, 8, data width
LEN_W, 5, burst length field width (lengths 0..2^ADDR_W meaningful)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  burst request valid
req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready
req_we  in  1  1 = write burst, 0 = read burst
req_addr  in  ADDR_W  burst base address
req_len  in  LEN_W  beats in burst
wr_data  in  DATA_W  host write data
wr_valid  in  1  write data valid
wr_ready  out  1  controller can take a write beat
rd_data  out  DATA_W  read beat data
rd_valid  out  1  read beat valid; no backpressure, host must accept
done  out  1  one-cycle pulse at burst end
mem_cs  out  1  SRAM chip select
mem_we  out  1  SRAM write enable
mem_addr  out  ADDR_W  SRAM address
mem_wdata  out  DATA_W  SRAM write data
mem_rdata  in  DATA_W  SRAM read data, valid the cycle after a read issue

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE. All outputs are 0 except req_ready, which is 1. Beat counter and address are 0. A reset mid-burst aborts the burst: no further mem_cs and no done pulse.
- All outputs are registered except req_ready and wr_ready, which are decoded from the current state.
- States: IDLE, WRITE, READ, DRAIN, DONE.
- Length rules: req_len is latched at acceptance. A length above 2^ADDR_W is clamped to 2^ADDR_W. A length of 0 goes IDLE -> DONE: done pulses the next cycle with no SRAM access.
- Address sequencing: each issued beat uses base + k mod 2^ADDR_W, for k = 0..L-1. Example: base 14, L 4 gives 14, 15, 0, 1.
- Write burst, accepted at cycle A:
  - WRITE is entered at A+1, and wr_ready = 1 throughout WRITE.
  - A beat transfers on wr_valid && wr_ready at cycle H.
  - At H+1: mem_cs = 1, mem_we = 1, mem_addr = next address, mem_wdata = wr_data.
  - Cycles with no handshake drive mem_cs = 0; gaps are allowed.
  - After the L-th handshake, the state goes to DONE and wr_ready drops.
  - done pulses in the same cycle as the final SRAM write, then the state returns to IDLE.
- Read burst, accepted at cycle A:
  - READ issues mem_cs = 1, mem_we = 0 on consecutive cycles A+1..A+L, with no gaps.
  - mem_rdata is captured one cycle after each issue. rd_valid/rd_data are registered and appear at A+3..A+L+2.
  - After the final issue the state goes to DRAIN until the last beat is returned.
  - done pulses coincident with the last rd_valid.
  - req_ready returns high at A+L+3.
- Simultaneous events: a request presented while not in IDLE is not accepted and must be held by the host. wr_valid outside WRITE is ignored. mem_we is never 1 while mem_cs is 0.
- Counters: the beat counter is LEN_W bits wide. Terminal count is compared against the clamped length, so there is no overflow at L = 2^ADDR_W.

Test Plan:
1. Reset with req_valid = 1 -> all outputs 0, req_ready = 1, no mem_cs. Release -> request accepted on the next edge.
2. Write burst: base 3, len 4, wr_data 0xA0..0xA3 back-to-back -> SRAM writes 3:A0, 4:A1, 5:A2, 6:A3 on 4 consecutive cycles; done on the 4th write.
3. Write with a wr_valid gap after beat 2 -> mem_cs low during the gap; addresses stay contiguous; done only after beat 4.
4. Read wrap: base 14, len 4 over preloaded memory -> mem_addr 14, 15, 0, 1. rd_valid is high for 4 cycles starting at A+3, carrying the matching data. done coincides with the last rd_valid.
5. Edge lengths: len 0 -> done at A+1, no mem_cs. len 20 -> clamped to 16, every address 0..15 accessed once from base 0.
6. Reset asserted during read beat 2 -> next cycle mem_cs = 0, rd_valid = 0, done never pulses, req_ready = 1.
